mpadd_seq: RTL and testbench
============================

MPADD_SEQ -- requirements
Module: mpadd_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, operand width in bytes (legal 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  requester has an operation.
REQ-005 SHALL have port req_ready  output  1  block accepts an operation.
REQ-006 SHALL have ports req_a, req_b  input  8*NBYTES  operands.
REQ-007 SHALL have port req_sub  input  1  0 = add, 1 = subtract.
REQ-008 SHALL have ports req_carry, req_cin  input  1 each  chain external carry-in (ADC/SBC) when req_carry=1.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-011 SHALL have ports rsp_q  output  8*NBYTES  result; rsp_cout  output  1  final carry.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL contain exactly one 8-bit addsub instance and process one byte per cycle, LSB first.
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on req_valid&&req_ready; RUN->DONE after NBYTES RUN cycles; DONE->IDLE on rsp_valid&&rsp_ready.
REQ-015 SHALL drive req_ready=1 only in IDLE; req_* ignored outside the accept edge.
REQ-016 SHALL latch req_a, req_b, req_sub, req_carry, req_cin on the accept edge; later changes have no effect.
REQ-017 SHALL drive addsub byte k from the latched operands; isSub=latched req_sub every byte.
REQ-018 SHALL drive byte 0 with isCarry=latched req_carry, cin=latched req_cin; bytes 1..NBYTES-1 with isCarry=1, cin=registered cout of byte k-1.
REQ-019 SHALL store each byte's q into rsp_q[8k+7:8k] and its cout into the carry register at the end of its RUN cycle.
REQ-020 SHALL produce: add rsp_q = A+B+c mod 2^(8N); sub rsp_q = A-B-(1-c) mod 2^(8N), where c=req_cin if req_carry else (sub?1:0); rsp_cout = carry-out of that sum (sub: 1 = no borrow).
REQ-021 SHALL assert rsp_valid exactly NBYTES cycles after the accept edge (latency NBYTES), in DONE only.
REQ-022 SHALL hold rsp_valid, rsp_q, rsp_cout stable while rsp_ready=0 (unbounded backpressure).
REQ-023 SHALL not accept a new request in the cycle the response handshakes; earliest next accept is the following cycle (one IDLE cycle minimum).
REQ-024 SHALL maintain rsp_q, rsp_cout at their last values in IDLE until overwritten by the next RUN.

Reset
REQ-025 SHALL on rst_n=0, immediately and regardless of clock: state=IDLE, byte counter=0, carry register=0, rsp_q=0, rsp_cout=0, rsp_valid=0, busy=0, req_ready=1.
REQ-026 SHALL abandon any operation in RUN or DONE on reset with no response emitted.

Configuration
REQ-027 SHALL, when macro MPADD_ZERO_FLAG_EN is defined, add output rsp_zero (1 bit), asserted with rsp_valid iff rsp_q==0, reset 0, cleared on accept and computed incrementally per byte.
REQ-028 SHALL, when MPADD_ZERO_FLAG_EN is undefined, omit rsp_zero and its logic entirely; all other behaviour identical.

Verification (NBYTES=4)
REQ-029 SHALL cover add 0x0000006A + 0x0000002C, req_carry=0 -> rsp_q=0x00000096, rsp_cout=0, rsp_valid exactly 4 cycles after accept.
REQ-030 SHALL cover add 0xFFFFFFFF + 0x00000001 -> rsp_q=0x00000000, rsp_cout=1, rsp_zero=1 (macro defined).
REQ-031 SHALL cover sub 0x00000100 - 0x00000001 -> rsp_q=0x000000FF, rsp_cout=1; sub 0x00000003 - 0x00000005 -> rsp_q=0xFFFFFFFE, rsp_cout=0.
REQ-032 SHALL cover SBC req_sub=1, req_carry=1, req_cin=0, 5-3 -> rsp_q=0x00000001; ADC req_cin=1, 0xFF+0xFF -> rsp_q=0x000001FF, rsp_cout=0.
REQ-033 SHALL cover rsp_ready held 0 for 10 cycles in DONE -> outputs stable, req_ready=0; changing req_a during RUN -> result unchanged.
REQ-034 SHALL cover rst_n pulsed low mid-RUN (byte 2) -> all outputs at reset values immediately, no rsp_valid, next request completes correctly.

Source files
------------

// File: rtl/mpadd_seq.sv
// Byte-serial multi-precision add/subtract: one 8-bit addsub processes NBYTES bytes LSB first.
// Optional zero-result flag output rsp_zero is enabled by defining MPADD_ZERO_FLAG_EN.

module mpadd_addsub (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       is_sub,
   input  logic       is_carry,
   input  logic       cin,
   output logic [7:0] q,
   output logic       cout
);
   logic       c0;
   logic [7:0] bx;
   logic [8:0] sum;

   // Without an explicit carry, subtract needs +1 to form two's complement.
   assign c0   = is_carry ? cin : is_sub;
   assign bx   = is_sub ? ~b : b;
   assign sum  = {1'b0, a} + {1'b0, bx} + {8'b0, c0};
   assign q    = sum[7:0];
   assign cout = sum[8];
endmodule

module mpadd_seq #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [8*NBYTES-1:0] req_a,
   input  logic [8*NBYTES-1:0] req_b,
   input  logic                req_sub,
   input  logic                req_carry,
   input  logic                req_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [8*NBYTES-1:0] rsp_q,
   output logic                rsp_cout,
`ifdef MPADD_ZERO_FLAG_EN
   output logic                rsp_zero,
`endif
   output logic                busy
);
   localparam int W  = 8 * NBYTES;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg;
   logic [W-1:0]    a_reg, b_reg, q_reg;
   logic            sub_reg, carry_en_reg, cin_reg, c_reg;
   logic            accept, last;
   logic [7:0]      a_bytes [NBYTES];
   logic [7:0]      b_bytes [NBYTES];
   logic [7:0]      q_byte;
   logic            is_carry, byte_cin, byte_cout;

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
         assign a_bytes[gi] = a_reg[8*gi +: 8];
         assign b_bytes[gi] = b_reg[8*gi +: 8];
      end
   endgenerate

   assign accept = req_valid && (state_reg == IDLE);
   assign last   = (cnt_reg == CW'(NBYTES - 1));

   // Byte 0 takes the requested carry mode; later bytes chain the registered carry.
   assign is_carry = (cnt_reg == '0) ? carry_en_reg : 1'b1;
   assign byte_cin = (cnt_reg == '0) ? cin_reg : c_reg;

   mpadd_addsub u_addsub (
      .a        (a_bytes[cnt_reg]),
      .b        (b_bytes[cnt_reg]),
      .is_sub   (sub_reg),
      .is_carry (is_carry),
      .cin      (byte_cin),
      .q        (q_byte),
      .cout     (byte_cout)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         q_reg        <= '0;
         sub_reg      <= 1'b0;
         carry_en_reg <= 1'b0;
         cin_reg      <= 1'b0;
         c_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg        <= req_a;
            b_reg        <= req_b;
            sub_reg      <= req_sub;
            carry_en_reg <= req_carry;
            cin_reg      <= req_cin;
            cnt_reg      <= '0;
         end else if (state_reg == RUN) begin
            c_reg   <= byte_cout;
            cnt_reg <= last ? '0 : cnt_reg + CW'(1);
            for (int i = 0; i < NBYTES; i++) begin
               if (cnt_reg == CW'(i)) q_reg[8*i +: 8] <= q_byte;
            end
         end
      end
   end

`ifdef MPADD_ZERO_FLAG_EN
   // Tracks whether any result byte so far was nonzero.
   logic nz_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nz_reg <= 1'b0;
      end else if (accept) begin
         nz_reg <= 1'b0;
      end else if (state_reg == RUN) begin
         nz_reg <= nz_reg | (|q_byte);
      end
   end

   assign rsp_zero = (state_reg == DONE) && !nz_reg;
`endif

   assign req_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign rsp_valid = (state_reg == DONE);
   assign rsp_q     = q_reg;
   assign rsp_cout  = c_reg;
endmodule

// File: tb/tb_mpadd_seq.sv
// Directed, table-driven bench for mpadd_seq (NBYTES=4) with backpressure and mid-run reset sequences.
`timescale 1ns/1ps

module tb_mpadd_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [31:0] req_a, req_b;
   logic        req_sub, req_carry, req_cin;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_q;
   logic        rsp_cout, busy;
`ifdef MPADD_ZERO_FLAG_EN
   logic        rsp_zero;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        carry;
      logic        cin;
      logic [31:0] q;
      logic        cout;
      logic        zero;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   mpadd_seq #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_carry (req_carry),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_q     (rsp_q),
      .rsp_cout  (rsp_cout),
`ifdef MPADD_ZERO_FLAG_EN
      .rsp_zero  (rsp_zero),
`endif
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with rsp_valid seen (or bound expired).
   task automatic start_op(input vec_t v, output int lat);
      req_a = v.a; req_b = v.b; req_sub = v.sub; req_carry = v.carry; req_cin = v.cin;
      req_valid = 1'b1;
      chk("req_ready_idle", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom;
      req_sub = ~v.sub; req_carry = ~v.carry; req_cin = ~v.cin;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input vec_t v);
      chk({tag, "_q"}, rsp_q, v.q);
      chk({tag, "_cout"}, rsp_cout, v.cout);
      chk({tag, "_ready_busy"}, {req_ready, busy}, 2'b01);
`ifdef MPADD_ZERO_FLAG_EN
      chk({tag, "_zero"}, rsp_zero, v.zero);
`endif
   endtask

   // Handshake with req_valid held high: the request must not be taken in that cycle.
   task automatic finish_op(input string tag, input vec_t v);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, "_post_hs"}, {busy, rsp_valid, req_ready}, 3'b001);
      req_valid = 1'b0;
      chk({tag, "_idle_hold_q"}, rsp_q, v.q);
   endtask

   task automatic run_op(input string tag, input vec_t v);
      int lat;
      start_op(v, lat);
      $display("op %s a=%08h b=%08h sub=%0b carry=%0b cin=%0b -> q=%08h cout=%0b lat=%0d",
               tag, v.a, v.b, v.sub, v.carry, v.cin, rsp_q, rsp_cout, lat);
      chk({tag, "_latency"}, lat, 4);
      check_result(tag, v);
      finish_op(tag, v);
   endtask

   initial begin
      int lat;
      vecs[0] = '{32'h0000006A, 32'h0000002C, 1'b0, 1'b0, 1'b0, 32'h00000096, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[2] = '{32'h00000100, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h000000FF, 1'b1, 1'b0};
      vecs[3] = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[4] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0};
      vecs[5] = '{32'h000000FF, 32'h000000FF, 1'b0, 1'b1, 1'b1, 32'h000001FF, 1'b0, 1'b0};
      vecs[6] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
      vecs[7] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[8] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_sub = 1'b0; req_carry = 1'b0; req_cin = 1'b0;
      #12;
      chk("reset_flags", {req_ready, busy, rsp_valid}, 3'b100);
      chk("reset_q", rsp_q, 32'h0);
      chk("reset_cout", rsp_cout, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i]);
      end

      // Backpressure: result and flags frozen for 10 cycles with rsp_ready low.
      start_op(vecs[6], lat);
      chk("bp_latency", lat, 4);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d", i), {rsp_valid, req_ready, rsp_cout, rsp_q}, {1'b1, 1'b0, 1'b0, 32'h99999999});
      end
      $display("op backpressure held 10 cycles q=%08h", rsp_q);
      finish_op("bp", vecs[6]);

      // Reset while processing byte 2: abandon the operation immediately.
      req_a = vecs[6].a; req_b = vecs[6].b; req_sub = 1'b0; req_carry = 1'b0; req_cin = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_run_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_flags", {req_ready, busy, rsp_valid}, 3'b100);
      chk("rst_mid_q", rsp_q, 32'h0);
      chk("rst_mid_cout", rsp_cout, 1'b0);
`ifdef MPADD_ZERO_FLAG_EN
      chk("rst_mid_zero", rsp_zero, 1'b0);
`endif
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rst_no_rsp%0d", i), {rsp_valid, busy}, 2'b00);
      end
      $display("op reset mid-run abandoned, no response");
      run_op("after_rst", vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
